// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: control, echo, trigger and result signals between a controller and the ranger
interface ultrasonic_ranger_if;
   logic       enable;
   logic       echo;
   logic       trig;
   logic [8:0] distance_cm;
   logic       dist_valid;
   logic       can_move_fwd;
   modport master (output enable, echo, input trig, distance_cm, dist_valid, can_move_fwd);
   modport slave (input enable, echo, output trig, distance_cm, dist_valid, can_move_fwd);
endinterface

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timing to centimetres with hysteretic forward-motion gate
module ultrasonic_ranger #(
   parameter int clk_hz     = 25000000,
   parameter int period_ms  = 60,
   parameter int trig_us    = 10,
   parameter int timeout_us = 30000,
   parameter int stop_cm    = 20,
   parameter int go_cm      = 25
) (
   input logic clk,
   input logic rst,
   ultrasonic_ranger_if.slave bus
);
   localparam int pre_n = clk_hz / 1000000;
   localparam int pre_w = pre_n > 1 ? $clog2(pre_n) : 1;
   localparam int per_n = period_ms * 1000;
   localparam int per_w = $clog2(per_n);
   localparam int cnt_w = $clog2(timeout_us + 1);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

   state_t     state_q, state_d;
   logic [pre_w-1:0] pre_q, pre_d;
   logic [per_w-1:0] per_q, per_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [5:0] sub_q, sub_d;
   logic [8:0] cm_q, cm_d, dist_q, dist_d;
   logic [2:0] echo_q, echo_d;
   logic       first_q, first_d, valid_q, valid_d, fwd_q, fwd_d, trig_q, trig_d;
   logic       tick, rise, fall;

   assign tick = pre_q == pre_w'(pre_n - 1);
   assign rise = echo_q[1] & ~echo_q[2];
   assign fall = ~echo_q[1] & echo_q[2];
   assign echo_d = {echo_q[1:0], bus.echo};

   always_comb begin
      state_d = state_q;
      pre_d   = '0;
      per_d   = '0;
      cnt_d   = cnt_q;
      sub_d   = sub_q;
      cm_d    = cm_q;
      first_d = first_q;
      dist_d  = dist_q;
      valid_d = 1'b0;
      fwd_d   = fwd_q;
      if (!bus.enable) begin
         state_d = IDLE;
      end else begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         per_d = (tick && per_q != per_w'(per_n - 1)) ? per_q + 1'b1 : per_q;
         case (state_q)
            IDLE: if (tick && (first_q || per_q == per_w'(per_n - 1))) begin
               state_d = TRIG;
               per_d   = '0;
               cnt_d   = '0;
               first_d = 1'b0;
            end
            TRIG: if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == cnt_w'(trig_us - 1)) begin
                  state_d = WAIT_RISE;
                  cnt_d   = '0;
                  cm_d    = '0;
               end
            end
            // the tick coinciding with the detected edge is counted so a W us echo yields exactly W ticks
            WAIT_RISE: if (rise) begin
               state_d = MEASURE;
               cnt_d   = tick ? cnt_w'(1) : '0;
               sub_d   = tick ? 6'd1 : 6'd0;
               cm_d    = '0;
            end else if (tick) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == cnt_w'(timeout_us - 1)) begin
                  state_d = DONE;
                  cm_d    = 9'd511;
               end
            end
            MEASURE: if (fall) begin
               state_d = DONE;
            end else if (tick) begin
               cnt_d = cnt_q + 1'b1;
               sub_d = sub_q == 6'd57 ? 6'd0 : sub_q + 6'd1;
               cm_d  = (sub_q == 6'd57 && cm_q != 9'd511) ? cm_q + 9'd1 : cm_q;
               if (cnt_q == cnt_w'(timeout_us - 1)) begin
                  state_d = DONE;
                  cm_d    = 9'd511;
               end
            end
            DONE: begin
               state_d = IDLE;
               dist_d  = cm_q;
               valid_d = 1'b1;
               fwd_d   = fwd_q ? cm_q >= 9'(stop_cm) : cm_q >= 9'(go_cm);
            end
            default: state_d = IDLE;
         endcase
      end
      trig_d = state_d == TRIG;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         per_q   <= '0;
         cnt_q   <= '0;
         sub_q   <= '0;
         cm_q    <= '0;
         echo_q  <= '0;
         first_q <= 1'b1;
         dist_q  <= 9'd511;
         valid_q <= 1'b0;
         fwd_q   <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         per_q   <= per_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
         cm_q    <= cm_d;
         echo_q  <= echo_d;
         first_q <= first_d;
         dist_q  <= dist_d;
         valid_q <= valid_d;
         fwd_q   <= fwd_d;
         trig_q  <= trig_d;
      end
   end

   assign bus.trig         = trig_q;
   assign bus.distance_cm  = dist_q;
   assign bus.dist_valid   = valid_q;
   assign bus.can_move_fwd = fwd_q;
endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Drives an HC-SR04-class ultrasonic sensor and converts its echo pulse width into a distance in centimetres. It sits directly upstream of `control` and produces the `can_move_fwd` gate that `control` uses to block forward motion, with hysteresis applied between a stop and a resume distance. The block fires the trigger pulse, measures the echo with a 1 µs timebase, and publishes one result per measurement period.

## Interface

Parameters:

- `clk_hz`, 25000000, system clock frequency. Must be an integer multiple of 1 MHz.
- `period_ms`, 60, trigger-to-trigger measurement period.
- `trig_us`, 10, width of the trigger pulse.
- `timeout_us`, 30000, maximum echo wait and echo width; beyond this the result is out of range.
- `stop_cm`, 20, `can_move_fwd` falls when distance < `stop_cm`.
- `go_cm`, 25, `can_move_fwd` rises when distance >= `go_cm`. Requires `go_cm` > `stop_cm`.

Ports:

- `clk`  in  1  system clock, one clock domain.
- `rst`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run measurements while high.
- `echo`  in  1  sensor echo, asynchronous; synchronised internally by 2 flip-flops.
- `trig`  out  1  sensor trigger.
- `distance_cm`  out  9  last measured distance; 511 means out of range or no echo.
- `dist_valid`  out  1  one-cycle strobe when `distance_cm` updates.
- `can_move_fwd`  out  1  forward-motion permission, with hysteresis.

## Operation

- **µs tick:** prescaler counts 0..`clk_hz`/1e6−1, giving a 1-cycle tick every 25 clocks. It runs freely while `enable` is high.
- **Centimetre accumulation:** no divider. A 0..57 µs sub-counter increments `cm_acc` each time it wraps, so distance = floor(echo_us / 58). `cm_acc` saturates at 511.
- **FSM states:**
  - **IDLE:** waits until the period counter reaches `period_ms`·1000 µs (counted from the last TRIG entry). At that point the period counter is cleared and the FSM moves to TRIG. On the first `enable` after reset, the FSM moves to TRIG on the next tick.
  - **TRIG:** `trig`=1 for `trig_us` ticks, then moves to WAIT_RISE. The wait counter and `cm_acc` are cleared.
  - **WAIT_RISE:** on a synchronised `echo` rising edge, moves to MEASURE. If the wait counter reaches `timeout_us`, `cm_acc` is forced to 511 and the FSM moves to DONE.
  - **MEASURE:** counts µs while echo is high. On the falling edge, moves to DONE. If the count reaches `timeout_us`, `cm_acc` is forced to 511 and the FSM moves to DONE.
  - **DONE:** 1 cycle. Latches `distance_cm` ← `cm_acc`, pulses `dist_valid`, applies hysteresis, then returns to IDLE.
- **Hysteresis (DONE only):**
  - If `can_move_fwd`=1 and `cm_acc` < `stop_cm`, it goes to 0.
  - If `can_move_fwd`=0 and `cm_acc` >= `go_cm`, it goes to 1.
  - Otherwise it holds.
  - 511 counts as far, so it permits motion.
- **Echo still high at the next TRIG** (timeout case): the trigger still fires. WAIT_RISE accepts only a low→high edge seen after TRIG ends.
- **`enable` low:** the FSM goes to IDLE on the next cycle, `trig` goes to 0, and the prescaler and period counter clear. `distance_cm` and `can_move_fwd` hold, and no `dist_valid` is issued for the aborted measurement.
- **Precedence:** on a simultaneous echo falling edge and timeout in MEASURE, the falling edge wins and the measured value is used.

## Timing

- **Reset values** (`rst`=0 at a `clk` edge): FSM=IDLE, `trig`=0, `distance_cm`=511, `dist_valid`=0, `can_move_fwd`=0 (safe until the first measurement). All counters are 0.
- **Reset mid-operation:** all measurement state is discarded and the reset values apply on the next edge.
- **Synchroniser latency:** 2 cycles from an `echo` pin change to the FSM seeing it. The resulting absolute error of up to ±1 tick is acceptable.
- **Output alignment:** `distance_cm`, `can_move_fwd` and `dist_valid` are registered and change in the same cycle. `dist_valid` is high for exactly 1 cycle.
- **Trigger pulse:** `trig` high time is exactly `trig_us`·25 cycles ±1 cycle.
- **Period:** trigger rising edges are spaced exactly `period_ms`·25000 cycles apart while `enable` stays high, independent of echo length.

## Test plan

- **10 cm, stop:** `rst` pulse, `enable`=1, echo high 580 µs after trigger → `distance_cm`=10, `dist_valid` 1 cycle, `can_move_fwd`=0.
- **Hysteresis band:** echo sequence 1450 µs, 1276 µs, 1102 µs, 1450 µs → distances 25, 22, 19, 25. `can_move_fwd` sequence is 1, 1, 0, 1; the value 22 must not toggle it.
- **No echo:** echo held low → `dist_valid` after 30000 µs in WAIT_RISE, `distance_cm`=511, `can_move_fwd`=1.
- **Long echo:** echo high for 40000 µs → result 511 at the 30000 µs MEASURE point. The next trigger still fires exactly 60 ms after the previous one, and its measurement waits for a fresh rising edge.
- **Trigger spacing and width:** consecutive `trig` rising edges are 1,500,000 cycles apart; each pulse is 250 cycles wide.
- **Reset and enable mid-measurement:**
  - Assert `rst`=0 during MEASURE → next cycle `trig`=0, `distance_cm`=511, `can_move_fwd`=0, no `dist_valid`.
  - Drop `enable` during MEASURE → prior outputs hold and no strobe is issued.
